// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Queues ALU commands in a FIFO and drives one at a time into a
//            1-cycle registered ALU, returning each result on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [WIDTH-1:0]   cmd_first_i,
    input  logic [WIDTH-1:0]   cmd_second_i,
    input  logic [2:0]         cmd_opcode_i,
    output logic [WIDTH-1:0]   alu_first_o,
    output logic [WIDTH-1:0]   alu_second_o,
    output logic [2:0]         alu_opcode_o,
    input  logic [WIDTH-1:0]   alu_result_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [WIDTH-1:0]   rsp_result_o,
    output logic [2:0]         rsp_opcode_o,
    output logic [COUNT_W-1:0] done_cnt_o
);

    localparam int c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_entry_w = 2 * WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_head;

    assign w_full      = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign cmd_ready_o = !w_full;
    assign w_push      = cmd_valid_i && !w_full;
    // The FSM pulls the next command either from IDLE or on the hand-off edge in RESP.
    assign w_pop       = !w_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready_i));
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_first_i, cmd_second_i, cmd_opcode_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            alu_first_o  <= '0;
            alu_second_o <= '0;
            alu_opcode_o <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_opcode_o <= '0;
            done_cnt_o   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        {alu_first_o, alu_second_o, alu_opcode_o} <= w_head;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    rsp_result_o <= alu_result_i;
                    rsp_opcode_o <= alu_opcode_o;
                    rsp_valid_o  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        done_cnt_o  <= done_cnt_o + COUNT_W'(1);
                        rsp_valid_o <= 1'b0;
                        if (w_pop) begin
                            {alu_first_o, alu_second_o, alu_opcode_o} <= w_head;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Directed bench for alu_cmd_sequencer with a registered ALU model
//            and a queue-based response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int COUNT_W = 4;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [WIDTH-1:0]   cmd_first;
    logic [WIDTH-1:0]   cmd_second;
    logic [2:0]         cmd_opcode;
    logic [WIDTH-1:0]   alu_first;
    logic [WIDTH-1:0]   alu_second;
    logic [2:0]         alu_opcode;
    logic [WIDTH-1:0]   alu_result;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    logic [2:0]         rsp_opcode;
    logic [COUNT_W-1:0] done_cnt;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [2:0]       op;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_cmd_sequencer #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_first_i  (cmd_first),
        .cmd_second_i (cmd_second),
        .cmd_opcode_i (cmd_opcode),
        .alu_first_o  (alu_first),
        .alu_second_o (alu_second),
        .alu_opcode_o (alu_opcode),
        .alu_result_i (alu_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_opcode_o (rsp_opcode),
        .done_cnt_o   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: 000 NAND, 001 ADD, 010 SUB, 011 AND, 100 SHL, 101 SRA, 110 SLT, 111 XOR
    function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a << b[2:0];
            3'd5:    return $signed(a) >>> b[2:0];
            3'd6:    return ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(alu_first, alu_second, alu_opcode);

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, waiting (bounded) for room; queue its expected response.
    task automatic push_cmd(input logic [7:0] a, b, input logic [2:0] op,
                            input logic [7:0] res, input bit want_rsp);
        int i;
        cmd_first  = a;
        cmd_second = b;
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        i = 0;
        while (!cmd_ready && i < 200) begin
            tick();
            i++;
        end
        check("push_accept", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready) begin
            tick();
            if (want_rsp) exp_q.push_back('{res: res, op: op});
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            tick();
            i++;
        end
        check(name, exp_q.size(), 32'd0);
        tick();
        tick();
    endtask

    // Scoreboard monitor: compares each handshaken response with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", {24'd0, rsp_result}, {24'd0, e.res});
                    check("rsp_opcode", {29'd0, rsp_opcode}, {29'd0, e.op});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int i;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_first  = '0;
        cmd_second = '0;
        cmd_opcode = '0;
        rsp_ready  = 1'b0;
        repeat (3) tick();

        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_first", {24'd0, alu_first}, 32'd0);
        check("rst_done_cnt",  {28'd0, done_cnt},  32'd0);
        rst = 1'b0;
        tick();

        // Latency: NAND F0,3C -> CF, valid exactly 3 edges after accept
        rsp_ready = 1'b1;
        push_cmd(8'hF0, 8'h3C, 3'd0, 8'hCF, 1'b1);
        check("lat_n",  {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lat_n1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lat_n2", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lat_n3", {31'd0, rsp_valid}, 32'd1);
        tick();
        check("done_after_1", {28'd0, done_cnt}, 32'd1);

        // Fill: leader in flight plus four queued, with consumer stalled
        rsp_ready = 1'b0;
        push_cmd(8'hF0, 8'h3C, 3'd0, 8'hCF, 1'b1);
        push_cmd(8'hFF, 8'h01, 3'd1, 8'h00, 1'b1);
        push_cmd(8'h80, 8'h01, 3'd5, 8'hC0, 1'b1);
        push_cmd(8'h01, 8'h03, 3'd4, 8'h08, 1'b1);
        push_cmd(8'h03, 8'h05, 3'd6, 8'h01, 1'b1);
        check("full_ready_low", {31'd0, cmd_ready}, 32'd0);

        // Stall in RESP for 10 cycles with an extra command waiting
        cmd_first  = 8'hAA;
        cmd_second = 8'h0F;
        cmd_opcode = 3'd3;
        cmd_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("hold_rsp_valid",  {31'd0, rsp_valid},  32'd1);
            check("hold_rsp_result", {24'd0, rsp_result}, 32'hCF);
            check("hold_alu_ops",    {8'd0, alu_first, alu_second, 5'd0, alu_opcode}, 32'h00F03C00);
            check("hold_cmd_ready",  {31'd0, cmd_ready},  32'd0);
            check("hold_done_cnt",   {28'd0, done_cnt},   32'd1);
        end

        // Pop edge with push attempted while full: push must be rejected
        rsp_ready = 1'b1;
        tick();
        check("pop_edge_ready", {31'd0, cmd_ready}, 32'd1);
        check("pop_edge_done",  {28'd0, done_cnt},  32'd2);
        check("pop_edge_alu_a", {24'd0, alu_first}, 32'hFF);
        tick();
        exp_q.push_back('{res: 8'h0A, op: 3'd3});
        cmd_valid = 1'b0;
        drain("drain_fill");
        check("done_after_fill", {28'd0, done_cnt}, 32'd7);

        // Reset while in CAPT with two commands queued
        push_cmd(8'h11, 8'h22, 3'd1, 8'h33, 1'b0);
        push_cmd(8'h44, 8'h01, 3'd1, 8'h45, 1'b0);
        push_cmd(8'h55, 8'h01, 3'd1, 8'h56, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        check("mid_rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        check("mid_rst_alu_first",  {24'd0, alu_first},  32'd0);
        check("mid_rst_alu_opcode", {29'd0, alu_opcode}, 32'd0);
        check("mid_rst_rsp_result", {24'd0, rsp_result}, 32'd0);
        check("mid_rst_done_cnt",   {28'd0, done_cnt},   32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_rst_quiet", {31'd0, rsp_valid}, 32'd0);
        end

        // 17 back-to-back ADDs: done counter wraps 15 -> 0 -> 1
        fork
            begin
                for (int k = 0; k < 17; k++) begin
                    push_cmd(8'(k), 8'(k + 1), 3'd1, 8'(2 * k + 1), 1'b1);
                end
            end
            begin
                i = 0;
                while (done_cnt != 4'd15 && i < 400) begin
                    @(negedge clk);
                    i++;
                end
                check("wrap_reach_15", {28'd0, done_cnt}, 32'd15);
                i = 0;
                while (done_cnt == 4'd15 && i < 400) begin
                    @(negedge clk);
                    i++;
                end
                check("wrap_to_0", {28'd0, done_cnt}, 32'd0);
                i = 0;
                while (done_cnt == 4'd0 && i < 400) begin
                    @(negedge clk);
                    i++;
                end
                check("wrap_to_1", {28'd0, done_cnt}, 32'd1);
            end
        join
        drain("drain_wrap");
        check("final_done_cnt",   {28'd0, done_cnt},  32'd1);
        check("final_rsp_valid",  {31'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
